// File: rtl/window_ctrl_13x13.sv
// Sequencing controller for the 13x13 window datapath: tracks raster position of accepted
// pixels, flags complete windows with their centre, and blocks input while the pipeline drains.
module window_ctrl_13x13 #(
    parameter int unsigned COLS = 15,
    parameter int unsigned ROWS = 15,
    parameter int unsigned K    = 13,
    parameter int unsigned LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      done_i,
    output logic                      ready_o,
    output logic                      shift_en_o,
    output logic                      done_o,
    output logic [$clog2(ROWS)-1:0]   ctr_row_o,
    output logic [$clog2(COLS)-1:0]   ctr_col_o,
    output logic                      progress_done_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    localparam logic [RW-1:0] RowLast    = RW'(ROWS - 1);
    localparam logic [CW-1:0] ColLast    = CW'(COLS - 1);
    localparam logic [RW-1:0] RowFirst   = RW'(K - 1);
    localparam logic [CW-1:0] ColFirst   = CW'(K - 1);
    localparam logic [RW-1:0] RowFillEnd = RW'(K - 2);
    localparam logic [RW-1:0] RowHalf    = RW'((K - 1) / 2);
    localparam logic [CW-1:0] ColHalf    = CW'((K - 1) / 2);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFill  = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] in_row_q, in_row_d;
    logic [CW-1:0] in_col_q, in_col_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic [LAT-1:0]         pipe_vld_q, pipe_vld_d;
    logic [LAT-1:0]         pipe_last_q, pipe_last_d;
    logic [LAT-1:0][RW-1:0] pipe_row_q, pipe_row_d;
    logic [LAT-1:0][CW-1:0] pipe_col_q, pipe_col_d;

    logic          col_last;
    logic          row_last;
    logic          frame_end;
    logic          fill_end;
    logic          win_vld;
    logic          win_last;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;

    assign ready_o    = (state_q != StDrain);
    assign shift_en_o = done_i & ready_o;

    assign col_last  = (in_col_q == ColLast);
    assign row_last  = (in_row_q == RowLast);
    assign frame_end = row_last & col_last;
    assign fill_end  = (in_row_q == RowFillEnd) & col_last;

    // The accepted pixel is the bottom-right tap, so the window centre trails it by half a window.
    assign win_vld  = shift_en_o & (in_row_q >= RowFirst) & (in_col_q >= ColFirst);
    assign win_last = shift_en_o & frame_end;
    assign win_row  = in_row_q - RowHalf;
    assign win_col  = in_col_q - ColHalf;

    always_comb begin
        in_row_d = in_row_q;
        in_col_d = in_col_q;
        if (shift_en_o) begin
            if (col_last) begin
                in_col_d = '0;
                in_row_d = row_last ? '0 : in_row_q + 1'b1;
            end else begin
                in_col_d = in_col_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (shift_en_o) begin
                    if (frame_end) begin
                        state_d = StDrain;
                    end else if (fill_end) begin
                        state_d = StRun;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                if (shift_en_o && frame_end) begin
                    state_d = StDrain;
                end else if (shift_en_o && fill_end) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (shift_en_o && frame_end) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Leave exactly when the last-window pulse is on the outputs.
                if (progress_done_o) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_d = (state_d != StIdle);
    assign err_d  = err_q | (done_i & ~ready_o);

    // Centre fields only load on a valid entry so the output stage holds the last valid centre.
    always_comb begin
        pipe_vld_d  = '0;
        pipe_last_d = '0;
        pipe_row_d  = pipe_row_q;
        pipe_col_d  = pipe_col_q;

        pipe_vld_d[0]  = win_vld;
        pipe_last_d[0] = win_last;
        if (win_vld) begin
            pipe_row_d[0] = win_row;
            pipe_col_d[0] = win_col;
        end

        for (int unsigned i = 1; i < LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
            if (pipe_vld_q[i-1]) begin
                pipe_row_d[i] = pipe_row_q[i-1];
                pipe_col_d[i] = pipe_col_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            in_row_q    <= '0;
            in_col_q    <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            pipe_row_q  <= '0;
            pipe_col_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_row_q    <= in_row_d;
            in_col_q    <= in_col_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            pipe_row_q  <= pipe_row_d;
            pipe_col_q  <= pipe_col_d;
        end
    end

    assign done_o          = pipe_vld_q[LAT-1];
    assign progress_done_o = pipe_vld_q[LAT-1] & pipe_last_q[LAT-1];
    assign ctr_row_o       = pipe_row_q[LAT-1];
    assign ctr_col_o       = pipe_col_q[LAT-1];
    assign busy_o          = busy_q;
    assign err_o           = err_q;

endmodule
